// File: rtl/user_bus_pkg.sv
// user_bus_pkg: shared FSM state encoding and beat-count width for the user bus RAM target
package user_bus_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;
  localparam int CNT_W = 9;
endpackage

// File: rtl/user_ram_sp.sv
// user_ram_sp: single-port RAM, byte write enables, 1-cycle registered read held when idle (ACLK, en, we, be, addr, wdata -> rdata)
module user_ram_sp #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic            ACLK,
  input  logic            en,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge ACLK) begin
    if (en && we)
      for (int i = 0; i < DW/8; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (en && !we) rdata <= mem[addr];
  end
endmodule

// File: rtl/user_bus_ram_target.sv
// user_bus_ram_target: burst RAM target (ACLK/ARESET, aw*/w* write channel, ar*/r* read channel), writes win over reads
module user_bus_ram_target
  import user_bus_pkg::*;
#(
  parameter int C_ADDR_WIDTH     = 32,
  parameter int C_DATA_WIDTH     = 32,
  parameter int C_MEM_ADDR_WIDTH = 10
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [C_ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]                awlen,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [C_DATA_WIDTH-1:0]   wdata,
  input  logic [C_DATA_WIDTH/8-1:0] wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [C_ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]                arlen,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [C_DATA_WIDTH-1:0]   rdata,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready
);
  localparam int SH = $clog2(C_DATA_WIDTH/8);
  localparam int MW = C_MEM_ADDR_WIDTH;
  state_t state, state_n;
  logic [MW-1:0] ptr, ptr_n, mem_addr, aw_idx, ar_idx;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic rvalid_n, rlast_n, mem_en, mem_we, issue;
  logic [C_DATA_WIDTH-1:0] mem_q;
  logic unused_ok;
  assign unused_ok = ^{wlast, awaddr, araddr};
  assign aw_idx = awaddr[SH +: MW];
  assign ar_idx = araddr[SH +: MW];
  assign rdata = rvalid ? mem_q : '0;
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    rvalid_n = rvalid;
    rlast_n = rlast;
    awready = 1'b0;
    wready = 1'b0;
    arready = 1'b0;
    mem_en = 1'b0;
    mem_we = 1'b0;
    mem_addr = ptr;
    issue = 1'b0;
    if (!ARESET)
      case (state)
        ST_IDLE: begin
          awready = 1'b1;
          wready = 1'b1;
          arready = !awvalid;
          if (awvalid) begin
            mem_en = wvalid;
            mem_we = 1'b1;
            mem_addr = aw_idx;
            ptr_n = aw_idx + MW'(wvalid);
            cnt_n = {1'b0, awlen} + CNT_W'(!wvalid);
            state_n = (awlen == 8'd0 && wvalid) ? ST_IDLE : ST_WRITE;
          end else if (arvalid) begin
            ptr_n = ar_idx;
            cnt_n = {1'b0, arlen} + CNT_W'(1);
            state_n = ST_READ;
          end
        end
        ST_WRITE: begin
          awready = 1'b1;
          wready = 1'b1;
          if (wvalid) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            ptr_n = ptr + MW'(1);
            cnt_n = cnt - CNT_W'(1);
            state_n = cnt == CNT_W'(1) ? ST_IDLE : ST_WRITE;
          end
        end
        ST_READ: begin
          issue = cnt != '0 && (!rvalid || rready);
          if (issue) begin
            mem_en = 1'b1;
            ptr_n = ptr + MW'(1);
            cnt_n = cnt - CNT_W'(1);
            rvalid_n = 1'b1;
            rlast_n = cnt == CNT_W'(1);
          end else if (rready) begin
            rvalid_n = 1'b0;
            rlast_n = 1'b0;
          end
          state_n = (rvalid && rready && rlast) ? ST_IDLE : ST_READ;
        end
        default: state_n = ST_IDLE;
      endcase
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= ST_IDLE;
      ptr <= '0;
      cnt <= '0;
      rvalid <= 1'b0;
      rlast <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      rvalid <= rvalid_n;
      rlast <= rlast_n;
    end
  end
  user_ram_sp #(.DW(C_DATA_WIDTH), .AW(MW)) u_ram (
    .ACLK  (ACLK),
    .en    (mem_en),
    .we    (mem_we),
    .be    (wstrb),
    .addr  (mem_addr),
    .wdata (wdata),
    .rdata (mem_q)
  );
endmodule
